// File: rtl/simd_pe.sv
// SIMD processing element: loads two operand vectors from shared memory chunk by
// chunk, applies a lanewise ADD/SUB/MUL/MAC and writes results back.
module simd_pe #(
  parameter int LANES  = 5,
  parameter int USIZE  = 16,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 10,
  localparam int BUS_W = LANES * USIZE,
  localparam int SW    = $clog2(LANES + 1)
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_en,
  input  logic              i_valid,
  input  logic [1:0]        i_cmd,
  input  logic [ADDR_W-1:0] i_payload,
  input  logic              i_grant_rd,
  input  logic              i_grant_wr,
  input  logic [BUS_W-1:0]  i_data,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_req_rd,
  output logic              o_req_wr,
  output logic [BUS_W-1:0]  o_data,
  output logic [SW-1:0]     o_wr_size,
  output logic              o_wr_en,
  output logic              o_busy,
  output logic              o_finish,
  output logic [3:0]        o_dbg_state
);

  // Handshake: a command is accepted on a rising edge where i_valid is high and
  // i_cmd matches the setup state; a memory access completes on a rising edge
  // where its request and the matching grant are both high.

  typedef enum logic [3:0] {
    S_IDLE, S_LD_A, S_LD_B, S_INFO, S_STORE,
    S_FETCH_A, S_FETCH_B, S_WRITE, S_FINISHED
  } state_t;

  localparam logic [1:0] CMD_LD    = 2'd0;
  localparam logic [1:0] CMD_INFO  = 2'd1;
  localparam logic [1:0] CMD_STORE = 2'd2;
  localparam logic [1:0] OP_ADD    = 2'd0;
  localparam logic [1:0] OP_SUB    = 2'd1;
  localparam logic [1:0] OP_MUL    = 2'd2;
  localparam logic [1:0] OP_MAC    = 2'd3;

  state_t state, state_n;

  logic [ADDR_W-1:0] addr_a, addr_b, wr_addr;
  logic [1:0]        op;
  logic [CNT_W-1:0]  count, remaining, chunk;
  logic [BUS_W-1:0]  reg_a, reg_b, acc;
  logic [BUS_W-1:0]  lane_res, mac_next;
  logic              last_chunk;

  assign chunk      = (remaining < CNT_W'(LANES)) ? remaining : CNT_W'(LANES);
  assign last_chunk = (remaining <= CNT_W'(LANES));

  function automatic logic [USIZE-1:0] alu(input logic [1:0] f,
                                           input logic [USIZE-1:0] a,
                                           input logic [USIZE-1:0] b);
    logic [USIZE-1:0] r;
    case (f)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      default: r = a * b;
    endcase
    return r;
  endfunction

  // MAC multiplies against i_data directly since reg_b is loaded in the same edge.
  always_comb begin
    lane_res = '0;
    mac_next = acc;
    for (int k = 0; k < LANES; k++) begin
      if (k < int'(chunk)) begin
        lane_res[BUS_W-1-k*USIZE -: USIZE] =
          alu(op, reg_a[BUS_W-1-k*USIZE -: USIZE], reg_b[BUS_W-1-k*USIZE -: USIZE]);
        mac_next[BUS_W-1-k*USIZE -: USIZE] = acc[BUS_W-1-k*USIZE -: USIZE] +
          alu(OP_MUL, reg_a[BUS_W-1-k*USIZE -: USIZE], i_data[BUS_W-1-k*USIZE -: USIZE]);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) state <= S_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:     if (i_en) state_n = S_LD_A;
      S_LD_A:     if (i_valid && i_cmd == CMD_LD) state_n = S_LD_B;
      S_LD_B:     if (i_valid && i_cmd == CMD_LD) state_n = S_INFO;
      S_INFO:     if (i_valid && i_cmd == CMD_INFO) state_n = S_STORE;
      S_STORE:    if (i_valid && i_cmd == CMD_STORE)
                    state_n = (count == '0) ? S_FINISHED : S_FETCH_A;
      S_FETCH_A:  if (i_grant_rd) state_n = S_FETCH_B;
      S_FETCH_B:  if (i_grant_rd)
                    state_n = (op != OP_MAC || last_chunk) ? S_WRITE : S_FETCH_A;
      S_WRITE:    if (i_grant_wr)
                    state_n = (op == OP_MAC || last_chunk) ? S_FINISHED : S_FETCH_A;
      S_FINISHED: if (i_valid) state_n = S_IDLE;
      default:    state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      addr_a    <= '0;
      addr_b    <= '0;
      wr_addr   <= '0;
      op        <= '0;
      count     <= '0;
      remaining <= '0;
      reg_a     <= '0;
      reg_b     <= '0;
      acc       <= '0;
    end else begin
      case (state)
        S_LD_A: if (i_valid && i_cmd == CMD_LD) addr_a <= i_payload;
        S_LD_B: if (i_valid && i_cmd == CMD_LD) addr_b <= i_payload;
        S_INFO: if (i_valid && i_cmd == CMD_INFO) begin
          op    <= i_payload[1:0];
          count <= i_payload[CNT_W+1:2];
        end
        S_STORE: if (i_valid && i_cmd == CMD_STORE) begin
          wr_addr   <= i_payload;
          remaining <= count;
          acc       <= '0;
        end
        S_FETCH_A: if (i_grant_rd) reg_a <= i_data;
        S_FETCH_B: if (i_grant_rd) begin
          reg_b <= i_data;
          if (op == OP_MAC) begin
            acc       <= mac_next;
            addr_a    <= addr_a + ADDR_W'(LANES);
            addr_b    <= addr_b + ADDR_W'(LANES);
            remaining <= remaining - chunk;
          end
        end
        S_WRITE: if (i_grant_wr && op != OP_MAC) begin
          addr_a    <= addr_a + ADDR_W'(LANES);
          addr_b    <= addr_b + ADDR_W'(LANES);
          wr_addr   <= wr_addr + ADDR_W'(LANES);
          remaining <= remaining - chunk;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_addr    = '0;
    o_req_rd  = 1'b0;
    o_req_wr  = 1'b0;
    o_data    = '0;
    o_wr_size = '0;
    o_wr_en   = 1'b0;
    case (state)
      S_FETCH_A: begin
        o_req_rd = 1'b1;
        o_addr   = addr_a;
      end
      S_FETCH_B: begin
        o_req_rd = 1'b1;
        o_addr   = addr_b;
      end
      S_WRITE: begin
        o_req_wr  = 1'b1;
        o_addr    = wr_addr;
        o_data    = (op == OP_MAC) ? acc : lane_res;
        o_wr_size = (op == OP_MAC) ? SW'(LANES) : SW'(chunk);
        o_wr_en   = i_grant_wr;
      end
      default: ;
    endcase
  end

  assign o_busy      = (state != S_IDLE);
  assign o_finish    = (state == S_FINISHED);
  assign o_dbg_state = state;

endmodule

// File: tb/tb_simd_pe.sv
// Bench for simd_pe: a memory model serves read/write requests with random grant
// stalls; expected traffic is computed from the operation rules over that memory.
module tb_simd_pe;
  localparam int LANES = 4, USIZE = 16, ADDR_W = 16, CNT_W = 10;
  localparam int BUS_W = 64, SW = 3;

  logic              clk = 1'b0;
  logic              rstn, en, valid, grant_rd, grant_wr;
  logic [1:0]        cmd;
  logic [ADDR_W-1:0] payload, addr;
  logic [BUS_W-1:0]  rdata, wdata;
  logic              req_rd, req_wr, wr_en, busy, finish;
  logic [SW-1:0]     wr_size;
  logic [3:0]        dbg_state;

  always #5 clk = ~clk;

  simd_pe #(.LANES(LANES), .USIZE(USIZE), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_en(en), .i_valid(valid), .i_cmd(cmd),
    .i_payload(payload), .i_grant_rd(grant_rd), .i_grant_wr(grant_wr),
    .i_data(rdata), .o_addr(addr), .o_req_rd(req_rd), .o_req_wr(req_wr),
    .o_data(wdata), .o_wr_size(wr_size), .o_wr_en(wr_en), .o_busy(busy),
    .o_finish(finish), .o_dbg_state(dbg_state)
  );

  logic [15:0] mem [0:65535];
  logic [15:0] exp_ra_q[$];
  logic [15:0] exp_wa_q[$];
  logic [63:0] exp_wd_q[$];
  logic [2:0]  exp_ws_q[$];
  logic [63:0] last_wd;
  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rd_bus(input logic [15:0] a);
    logic [63:0] v = '0;
    for (int k = 0; k < 4; k++) v[63-16*k -: 16] = mem[a + 16'(k)];
    return v;
  endfunction

  function automatic logic [15:0] ref_lane(input logic [1:0] f, input logic [15:0] a,
                                           input logic [15:0] b);
    logic [15:0] r;
    case (f)
      2'd0:    r = a + b;
      2'd1:    r = a - b;
      default: r = a * b;
    endcase
    return r;
  endfunction

  // Expected read addresses and writes for one whole operation.
  task automatic build_expect(input logic [1:0] f, input int cnt, input logic [15:0] a,
                              input logic [15:0] b, input logic [15:0] dst);
    logic [15:0] acc [4];
    logic [63:0] d;
    int ch;
    for (int k = 0; k < 4; k++) acc[k] = '0;
    for (int c = 0; c < cnt; c += 4) begin
      ch = (cnt - c < 4) ? cnt - c : 4;
      exp_ra_q.push_back(16'(a + 16'(c)));
      exp_ra_q.push_back(16'(b + 16'(c)));
      d = '0;
      for (int k = 0; k < ch; k++) begin
        logic [15:0] ea, eb;
        ea = mem[16'(a + 16'(c + k))];
        eb = mem[16'(b + 16'(c + k))];
        if (f == 2'd3) acc[k] = acc[k] + ref_lane(2'd2, ea, eb);
        else           d[63-16*k -: 16] = ref_lane(f, ea, eb);
      end
      if (f != 2'd3) begin
        exp_wa_q.push_back(16'(dst + 16'(c)));
        exp_wd_q.push_back(d);
        exp_ws_q.push_back(3'(ch));
      end
    end
    if (f == 2'd3 && cnt > 0) begin
      d = {acc[0], acc[1], acc[2], acc[3]};
      exp_wa_q.push_back(dst);
      exp_wd_q.push_back(d);
      exp_ws_q.push_back(3'd4);
    end
  endtask

  task automatic send(input logic [1:0] c, input logic [15:0] p);
    valid = 1'b1; cmd = c; payload = p;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic setup(input logic [1:0] f, input int cnt, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] dst, input bit bad);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    chk("busy_after_en", 64'(busy), 64'd1);
    if (bad) send(2'd2, 16'hdead);
    send(2'd0, a);
    if (bad) send(2'd1, 16'hbeef);
    send(2'd0, b);
    send(2'd1, {4'd0, 10'(cnt), f});
    if (bad) send(2'd3, 16'h1234);
    send(2'd2, dst);
  endtask

  task automatic service(input int grant_pct, output int cycles);
    int rd_seen = 0, wr_seen = 0;
    int rd_exp = exp_ra_q.size();
    int wr_exp = exp_wa_q.size();
    cycles = 0;
    while (!finish && cycles < 400) begin
      chk("req_exclusive", 64'(req_rd & req_wr), 64'd0);
      grant_rd = req_rd && ($urandom_range(99) < grant_pct);
      grant_wr = req_wr && ($urandom_range(99) < grant_pct);
      rdata = grant_rd ? rd_bus(addr) : {$urandom, $urandom};
      #1;
      if (grant_rd) begin
        rd_seen++;
        if (exp_ra_q.size() > 0) chk("rd_addr", 64'(addr), 64'(exp_ra_q.pop_front()));
      end
      if (req_wr) chk("wr_en_follows_grant", 64'(wr_en), 64'(grant_wr));
      if (wr_en) begin
        wr_seen++;
        last_wd = wdata;
        if (exp_wa_q.size() > 0) begin
          chk("wr_addr", 64'(addr), 64'(exp_wa_q.pop_front()));
          chk("wr_data", wdata, exp_wd_q.pop_front());
          chk("wr_size", 64'(wr_size), 64'(exp_ws_q.pop_front()));
        end
      end
      @(negedge clk);
      grant_rd = 1'b0;
      grant_wr = 1'b0;
      cycles++;
    end
    chk("finish_reached", 64'(finish), 64'd1);
    chk("rd_count", 64'(rd_seen), 64'(rd_exp));
    chk("wr_count", 64'(wr_seen), 64'(wr_exp));
    exp_ra_q.delete(); exp_wa_q.delete(); exp_wd_q.delete(); exp_ws_q.delete();
  endtask

  task automatic ack_finish();
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    chk("finish_holds", 64'(finish), 64'd1);
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    chk("idle_after_ack_busy", 64'(busy), 64'd0);
    chk("idle_after_ack_finish", 64'(finish), 64'd0);
  endtask

  task automatic run_op(input logic [1:0] f, input int cnt, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] dst, input int pct,
                        input bit bad);
    int cyc, nch, lat;
    build_expect(f, cnt, a, b, dst);
    setup(f, cnt, a, b, dst, bad);
    service(pct, cyc);
    nch = (cnt + 3) / 4;
    lat = (cnt == 0) ? 0 : (f == 2'd3) ? 2 * nch + 1 : 3 * nch;
    if (pct == 100) chk("latency", 64'(cyc), 64'(lat));
    ack_finish();
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_out"}, 64'({req_rd, req_wr, wr_en, busy, finish}), 64'd0);
    chk({tag, "_addr"}, 64'(addr), 64'd0);
    chk({tag, "_size"}, 64'(wr_size), 64'd0);
    chk({tag, "_data"}, wdata, 64'd0);
  endtask

  initial begin
    rstn = 1'b0; en = 1'b0; valid = 1'b0; cmd = '0; payload = '0;
    grant_rd = 1'b0; grant_wr = 1'b0; rdata = '0; last_wd = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    check_idle("reset");
    chk("reset_state", 64'(dbg_state), 64'd0);

    // ADD, one full chunk
    for (int k = 0; k < 4; k++) begin
      mem[16'h10 + k] = 16'(k + 1);
      mem[16'h20 + k] = 16'(10 * (k + 1));
    end
    run_op(2'd0, 4, 16'h10, 16'h20, 16'h80, 100, 1'b0);
    chk("add_data_const", last_wd, 64'h000b_0016_0021_002c);

    // SUB, partial second chunk
    run_op(2'd1, 6, 16'h10, 16'h20, 16'h80, 100, 1'b0);
    chk("sub_tail_zero", 64'(last_wd[31:0]), 64'd0);

    // MUL wraparound
    mem[16'h30] = 16'h0100; mem[16'h31] = 16'hffff;
    mem[16'h40] = 16'h0100; mem[16'h41] = 16'h0002;
    run_op(2'd2, 2, 16'h30, 16'h40, 16'h90, 100, 1'b0);
    chk("mul_data_const", last_wd, 64'h0000_fffe_0000_0000);

    // MAC over two chunks
    for (int k = 0; k < 8; k++) begin
      mem[16'h50 + k] = (k < 4) ? 16'd1 : 16'd2;
      mem[16'h60 + k] = (k < 4) ? 16'd3 : 16'd4;
    end
    run_op(2'd3, 8, 16'h50, 16'h60, 16'ha0, 100, 1'b0);
    chk("mac_data_const", last_wd, 64'h000b_000b_000b_000b);

    // Zero count, with ignored wrong commands in setup
    run_op(2'd0, 0, 16'h10, 16'h20, 16'h80, 100, 1'b1);

    // Read grant withheld in FETCH_B, then reset during WRITE
    setup(2'd0, 4, 16'h10, 16'h20, 16'h90, 1'b0);
    grant_rd = 1'b1; rdata = rd_bus(16'h10);
    @(negedge clk);
    grant_rd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rdata = {$urandom, $urandom};
      chk("stall_req_rd", 64'(req_rd), 64'd1);
      chk("stall_addr_b", 64'(addr), 64'h20);
      @(negedge clk);
    end
    chk("stall_addr_after", 64'(addr), 64'h20);
    grant_rd = 1'b1; rdata = rd_bus(16'h20);
    @(negedge clk);
    grant_rd = 1'b0;
    chk("in_write_req_wr", 64'(req_wr), 64'd1);
    chk("in_write_addr", 64'(addr), 64'h90);
    rstn = 1'b0;
    @(negedge clk);
    check_idle("midrun_reset");
    rstn = 1'b1;

    // Randomized operations with grant stalls
    for (int t = 0; t < 14; t++) begin
      logic [1:0]  f;
      logic [15:0] a, b, d;
      f = 2'($urandom_range(3));
      a = (t == 3) ? 16'hfffe : 16'($urandom);
      b = 16'($urandom);
      d = (t == 5) ? 16'hfffd : 16'($urandom);
      run_op(f, $urandom_range(13), a, b, d, (t % 3 == 0) ? 100 : 60, 1'($urandom_range(1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
